// File: rtl/wb_write_queue.sv
// Register-file write queue: merges ALU and MDU writeback results into an in-order FIFO,
// drains one entry per cycle onto the write port and forwards in-flight values to decode.
module wb_write_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [AW-1:0]            alu_rd,
  input  logic [DW-1:0]            alu_data,
  output logic                     alu_ready,
  input  logic                     mdu_valid,
  input  logic [AW-1:0]            mdu_rd,
  input  logic [DW-1:0]            mdu_data,
  output logic                     mdu_ready,
  output logic                     wb_wen,
  output logic [AW-1:0]            wb_rd,
  output logic [DW-1:0]            wb_data,
  input  logic [AW-1:0]            rs_addr,
  output logic                     rs_hit,
  output logic [DW-1:0]            rs_fwd,
  input  logic [AW-1:0]            rt_addr,
  output logic                     rt_hit,
  output logic [DW-1:0]            rt_fwd,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic          hit;
    logic [DW-1:0] data;
  } fwd_t;

  logic [AW-1:0] mem_rd   [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr_2nd;
  logic          alu_push;
  logic          mdu_push;
  logic          pop;
  logic [CW-1:0] push_cnt;
  fwd_t          rs_l;
  fwd_t          rt_l;

  // Readiness looks only at the registered count; the pop in the same cycle is not credited.
  always_comb begin
    alu_ready = (count <= CW'(DEPTH - 1));
    if (alu_valid) mdu_ready = (count <= CW'(DEPTH - 2));
    else           mdu_ready = (count <= CW'(DEPTH - 1));
  end

  always_comb begin
    alu_push   = alu_valid && alu_ready && (alu_rd != '0);
    mdu_push   = mdu_valid && mdu_ready && (mdu_rd != '0);
    pop        = (count != '0);
    wr_ptr_2nd = alu_push ? wr_ptr + 1'b1 : wr_ptr;
    push_cnt   = CW'(alu_push) + CW'(mdu_push);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      wb_wen  <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else begin
      count  <= count + push_cnt - CW'(pop);
      wr_ptr <= wr_ptr + PW'(push_cnt);
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        wb_wen  <= 1'b1;
        wb_rd   <= mem_rd[rd_ptr];
        wb_data <= mem_data[rd_ptr];
      end else begin
        wb_wen  <= 1'b0;
      end
    end
  end

  // The ALU entry takes the first free slot so it drains ahead of a same-cycle MDU entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (alu_push) begin
        mem_rd[wr_ptr]   <= alu_rd;
        mem_data[wr_ptr] <= alu_data;
      end
      if (mdu_push) begin
        mem_rd[wr_ptr_2nd]   <= mdu_rd;
        mem_data[wr_ptr_2nd] <= mdu_data;
      end
    end
  end

  // Scan oldest to youngest so the last match (youngest) wins; the wb stage is oldest of all.
  function automatic fwd_t lookup(input logic [AW-1:0] addr);
    fwd_t          r;
    logic [PW-1:0] idx;
    r = '0;
    if (addr != '0) begin
      if (wb_wen && (wb_rd == addr)) begin
        r.hit  = 1'b1;
        r.data = wb_data;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        idx = rd_ptr + PW'(i);
        if ((CW'(i) < count) && (mem_rd[idx] == addr)) begin
          r.hit  = 1'b1;
          r.data = mem_data[idx];
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    rs_l   = lookup(rs_addr);
    rt_l   = lookup(rt_addr);
    rs_hit = rs_l.hit;
    rs_fwd = rs_l.data;
    rt_hit = rt_l.hit;
    rt_fwd = rt_l.data;
  end

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue: per-cycle vector table plus fill, drain and
// mid-stream reset sequences checked against a small occupancy/order model.
module tb_wb_write_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mdu_valid;
  logic [4:0]  alu_rd, mdu_rd, rs_addr, rt_addr, wb_rd;
  logic [31:0] alu_data, mdu_data, wb_data, rs_fwd, rt_fwd;
  logic        alu_ready, mdu_ready, wb_wen, rs_hit, rt_hit;
  logic [2:0]  count;

  int n_chk  = 0;
  int n_fail = 0;

  wb_write_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data),
    .rs_addr(rs_addr), .rs_hit(rs_hit), .rs_fwd(rs_fwd),
    .rt_addr(rt_addr), .rt_hit(rt_hit), .rt_fwd(rt_fwd),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        r;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        e_ar;
    logic        e_mr;
    logic        e_wen;
    logic [4:0]  e_wrd;
    logic [31:0] e_wd;
    logic        e_rsh;
    logic [31:0] e_rsf;
    logic        e_rth;
    logic [31:0] e_rtf;
    logic [2:0]  e_cnt;
  } vec_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  vec_t tbl [10];
  ent_t q [$];
  int   mcount;
  bit   exp_wen;
  bit   saw_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic r, input logic av, input logic [4:0] ard, input logic [31:0] ad,
    input logic mv, input logic [4:0] mrd, input logic [31:0] md,
    input logic [4:0] rs, input logic [4:0] rt,
    input logic ear, input logic emr, input logic ew, input logic [4:0] ewrd,
    input logic [31:0] ewd, input logic ersh, input logic [31:0] ersf,
    input logic erth, input logic [31:0] ertf, input logic [2:0] ecnt);
    return '{r, av, ard, ad, mv, mrd, md, rs, rt,
             ear, emr, ew, ewrd, ewd, ersh, ersf, erth, ertf, ecnt};
  endfunction

  task automatic drive(input logic r, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic [4:0] rs, input logic [4:0] rt);
    rst = r; alu_valid = av; alu_rd = ard; alu_data = ad;
    mdu_valid = mv; mdu_rd = mrd; mdu_data = md; rs_addr = rs; rt_addr = rt;
  endtask

  // One cycle of the fill/drain model: check, then account for this cycle's handshakes.
  task automatic model_cycle(input logic av, input logic mv, input int k);
    ent_t e;
    bit   e_ar, e_mr;
    @(negedge clk);
    drive(1'b0, av, 5'(2*k+1), 32'hA000 + 32'(k), mv, 5'(2*k+2), 32'hB000 + 32'(k), 5'd0, 5'd0);
    #1;
    e_ar = (mcount <= 3);
    e_mr = av ? (mcount <= 2) : (mcount <= 3);
    chk("fill_count", 32'(count), 32'(mcount));
    chk("fill_alu_ready", 32'(alu_ready), 32'(e_ar));
    chk("fill_mdu_ready", 32'(mdu_ready), 32'(e_mr));
    chk("fill_wb_wen", 32'(wb_wen), 32'(exp_wen));
    if (exp_wen && q.size() > 0) begin
      e = q.pop_front();
      chk("fill_wb_rd", 32'(wb_rd), 32'(e.rd));
      chk("fill_wb_data", wb_data, e.d);
    end
    if (mcount == 3 && !mdu_ready && e_ar) saw_stall = 1'b1;
    e_ar = e_ar && av;
    e_mr = e_mr && mv;
    if (e_ar) q.push_back({alu_rd, alu_data});
    if (e_mr) q.push_back({mdu_rd, mdu_data});
    exp_wen = (mcount != 0);
    mcount  = mcount + int'(e_ar) + int'(e_mr) - int'(mcount != 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            r  av ard   ad            mv mrd   md       rs    rt   | ar mr wen wrd   wd            rsh rsf           rth rtf           cnt
    tbl[0] = mk(1, 1, 5'd5, 32'hAAAA,     1, 5'd6, 32'hBBBB, 5'd5, 5'd6,  1, 1, 0, 5'd0, 32'h0,        0, 32'h0,        0, 32'h0,        3'd0);
    tbl[1] = mk(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,    5'd5, 5'd0,  1, 1, 0, 5'd0, 32'h0,        0, 32'h0,        0, 32'h0,        3'd0);
    tbl[2] = mk(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    5'd5, 5'd5,  1, 1, 0, 5'd0, 32'h0,        1, 32'hDEADBEEF, 1, 32'hDEADBEEF, 3'd1);
    tbl[3] = mk(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    5'd5, 5'd6,  1, 1, 1, 5'd5, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 32'h0,        3'd0);
    tbl[4] = mk(0, 1, 5'd3, 32'h11,       1, 5'd3, 32'h22,   5'd3, 5'd5,  1, 1, 0, 5'd5, 32'hDEADBEEF, 0, 32'h0,        0, 32'h0,        3'd0);
    tbl[5] = mk(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    5'd3, 5'd3,  1, 1, 0, 5'd5, 32'hDEADBEEF, 1, 32'h22,       1, 32'h22,       3'd2);
    tbl[6] = mk(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    5'd3, 5'd7,  1, 1, 1, 5'd3, 32'h11,       1, 32'h22,       0, 32'h0,        3'd1);
    tbl[7] = mk(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    5'd3, 5'd0,  1, 1, 1, 5'd3, 32'h22,       1, 32'h22,       0, 32'h0,        3'd0);
    tbl[8] = mk(0, 1, 5'd0, 32'h55,       0, 5'd0, 32'h0,    5'd0, 5'd3,  1, 1, 0, 5'd3, 32'h22,       0, 32'h0,        0, 32'h0,        3'd0);
    tbl[9] = mk(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,    5'd0, 5'd3,  1, 1, 0, 5'd3, 32'h22,       0, 32'h0,        0, 32'h0,        3'd0);

    // Reset held with every input active before the first table row.
    drive(1'b1, 1'b1, 5'd5, 32'hAAAA, 1'b1, 5'd6, 32'hBBBB, 5'd5, 5'd6);
    @(posedge clk);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(tbl[i].r, tbl[i].av, tbl[i].ard, tbl[i].ad, tbl[i].mv, tbl[i].mrd, tbl[i].md,
            tbl[i].rs, tbl[i].rt);
      #1;
      chk($sformatf("v%0d_alu_ready", i), 32'(alu_ready), 32'(tbl[i].e_ar));
      chk($sformatf("v%0d_mdu_ready", i), 32'(mdu_ready), 32'(tbl[i].e_mr));
      chk($sformatf("v%0d_wb_wen", i),    32'(wb_wen),    32'(tbl[i].e_wen));
      chk($sformatf("v%0d_wb_rd", i),     32'(wb_rd),     32'(tbl[i].e_wrd));
      chk($sformatf("v%0d_wb_data", i),   wb_data,        tbl[i].e_wd);
      chk($sformatf("v%0d_rs_hit", i),    32'(rs_hit),    32'(tbl[i].e_rsh));
      chk($sformatf("v%0d_rs_fwd", i),    rs_fwd,         tbl[i].e_rsf);
      chk($sformatf("v%0d_rt_hit", i),    32'(rt_hit),    32'(tbl[i].e_rth));
      chk($sformatf("v%0d_rt_fwd", i),    rt_fwd,         tbl[i].e_rtf);
      chk($sformatf("v%0d_count", i),     32'(count),     32'(tbl[i].e_cnt));
    end

    // Fill with DEPTH+2 back-to-back dual pushes, then drain and confirm order.
    mcount = 0; exp_wen = 1'b0; saw_stall = 1'b0;
    for (int k = 0; k < 6; k++) model_cycle(1'b1, 1'b1, k);
    for (int k = 0; k < 12 && (q.size() > 0 || exp_wen); k++) model_cycle(1'b0, 1'b0, 0);
    chk("drain_empty", 32'(q.size()), 32'd0);
    chk("mdu_stall_seen", 32'(saw_stall), 32'd1);

    // Reset with three entries queued.
    @(negedge clk);
    drive(1'b0, 1'b1, 5'd20, 32'hC0, 1'b1, 5'd21, 32'hC1, 5'd0, 5'd0);
    @(negedge clk);
    drive(1'b0, 1'b1, 5'd22, 32'hC2, 1'b1, 5'd23, 32'hC3, 5'd0, 5'd0);
    @(negedge clk);
    drive(1'b1, 1'b1, 5'd24, 32'hC4, 1'b1, 5'd25, 32'hC5, 5'd22, 5'd23);
    #1;
    chk("pre_rst_count", 32'(count), 32'd3);
    chk("pre_rst_rs_hit", 32'(rs_hit), 32'd1);
    chk("pre_rst_rs_fwd", rs_fwd, 32'hC2);
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd22, 5'd23);
    #1;
    chk("post_rst_wb_wen", 32'(wb_wen), 32'd0);
    chk("post_rst_count", 32'(count), 32'd0);
    chk("post_rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("post_rst_wb_data", wb_data, 32'd0);
    chk("post_rst_rs_hit", 32'(rs_hit), 32'd0);
    chk("post_rst_rt_hit", 32'(rt_hit), 32'd0);
    @(negedge clk);
    #1;
    chk("post_rst2_wb_wen", 32'(wb_wen), 32'd0);
    chk("post_rst2_count", 32'(count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
